// File: rtl/multi_bank_arb_ram_if.sv
// Request/response bus of the banked RAM: per-port valid/ready requests, fixed-latency read responses.
// No response backpressure; requests stall only while req_ready is low.
interface multi_bank_arb_ram_if #(
   parameter int PORTS = 4,
   parameter int WIDTH = 16,
   parameter int ADDR  = 10,
   parameter int WE    = WIDTH / 8
);
   logic [PORTS-1:0]       req_valid;
   logic [PORTS-1:0]       req_ready;
   logic [PORTS*WE-1:0]    req_we;
   logic [PORTS*ADDR-1:0]  req_addr;
   logic [PORTS*WIDTH-1:0] req_wdata;
   logic [PORTS-1:0]       rsp_valid;
   logic [PORTS*WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/multi_bank_arb_ram.sv
// Multi-port RAM over address-interleaved banks with per-bank round-robin arbitration.
// Reads return 2 cycles after acceptance; conflicting requests wait with req_ready low.
module multi_bank_arb_ram #(
   parameter int BANKS   = 4,
   parameter int PORTS   = 4,
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 256,
   parameter int ADDR    = $clog2(BANKS * DEPTH),
   parameter int WE      = WIDTH / 8,
   parameter int STALL_W = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   multi_bank_arb_ram_if.slave  bus,
   output logic [31:0]          stall_cnt
);
   localparam int BB = $clog2(BANKS);
   localparam int RW = ADDR - BB;
   localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

   logic [BB-1:0]      pbank   [PORTS];
   logic [RW-1:0]      prow    [PORTS];
   logic [PW-1:0]      rr_ptr  [BANKS];
   logic [PW-1:0]      rr_nxt  [BANKS];
   logic [PW-1:0]      gsel    [BANKS];
   logic [BANKS-1:0]   gany;
   logic [PORTS-1:0]   ready;
   logic [PORTS-1:0]   rd_acc;
   logic [WIDTH-1:0]   bank_rd [BANKS];
   logic [PORTS-1:0]   s1_vld, s2_vld, rsp_vld_q;
   logic [BB-1:0]      s1_bank [PORTS];
   logic [WIDTH-1:0]   s2_dat  [PORTS];
   logic [PORTS*WIDTH-1:0] rsp_dat_q;
   logic [STALL_W-1:0] stall_q;

   always_comb begin
      for (int p = 0; p < PORTS; p++) begin
         pbank[p]  = bus.req_addr[p*ADDR +: BB];
         prow[p]   = bus.req_addr[p*ADDR+BB +: RW];
         rd_acc[p] = 1'b0;
      end
      for (int p = 0; p < PORTS; p++)
         rd_acc[p] = ready[p] && bus.req_valid[p] && (bus.req_we[p*WE +: WE] == '0);
   end

   // Per bank: first requester at or after rr_ptr, wrapping upward through the ports.
   always_comb begin
      int idx;
      int nx;
      idx   = 0;
      nx    = 0;
      ready = '0;
      gany  = '0;
      for (int b = 0; b < BANKS; b++) begin
         gsel[b]   = '0;
         rr_nxt[b] = rr_ptr[b];
         for (int i = 0; i < PORTS; i++) begin
            idx = int'(rr_ptr[b]) + i;
            if (idx >= PORTS) idx = idx - PORTS;
            if (!gany[b] && bus.req_valid[PW'(idx)] && pbank[PW'(idx)] == BB'(b)) begin
               gany[b]            = 1'b1;
               gsel[b]            = PW'(idx);
               ready[PW'(idx)]    = 1'b1;
               nx                 = (idx + 1 == PORTS) ? 0 : idx + 1;
               rr_nxt[b]          = PW'(nx);
            end
         end
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = rsp_vld_q;
   assign bus.rsp_rdata = rsp_dat_q;
   assign stall_cnt     = 32'(stall_q);

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic [WIDTH-1:0] mem [DEPTH];
      logic [WIDTH-1:0] rd_q;
      logic [WE-1:0]    bwe;
      logic [RW-1:0]    brow;
      logic [WIDTH-1:0] bwd;

      always_comb begin
         bwe  = bus.req_we[gsel[b]*WE +: WE];
         brow = prow[gsel[b]];
         bwd  = bus.req_wdata[gsel[b]*WIDTH +: WIDTH];
      end

      always_ff @(posedge clk) begin
         if (gany[b]) begin
            for (int k = 0; k < WE; k++)
               if (bwe[k]) mem[brow][k*8 +: 8] <= bwd[k*8 +: 8];
            if (bwe == '0) rd_q <= mem[brow];
         end
      end

      assign bank_rd[b] = rd_q;
   end

   // Data path stages carry no reset; only the valid bits are cleared so in-flight reads vanish.
   always_ff @(posedge clk) begin
      for (int p = 0; p < PORTS; p++) begin
         s1_bank[p] <= pbank[p];
         s2_dat[p]  <= bank_rd[s1_bank[p]];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_vld    <= '0;
         s2_vld    <= '0;
         rsp_vld_q <= '0;
         rsp_dat_q <= '0;
         stall_q   <= '0;
         for (int b = 0; b < BANKS; b++) rr_ptr[b] <= '0;
      end else begin
         s1_vld    <= rd_acc;
         s2_vld    <= s1_vld;
         rsp_vld_q <= s2_vld;
         for (int p = 0; p < PORTS; p++)
            if (s2_vld[p]) rsp_dat_q[p*WIDTH +: WIDTH] <= s2_dat[p];
         for (int b = 0; b < BANKS; b++) rr_ptr[b] <= rr_nxt[b];
         if (|(bus.req_valid & ~ready) && stall_q != '1)
            stall_q <= stall_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_multi_bank_arb_ram.sv
// Directed bench for multi_bank_arb_ram (BANKS=4, PORTS=2) with a transaction-level model
// compared every cycle, plus literal checks on the key scenarios.
module tb_multi_bank_arb_ram;
   localparam int BANKS = 4;
   localparam int PORTS = 2;
   localparam int WIDTH = 16;
   localparam int DEPTH = 16;
   localparam int ADDR  = 6;
   localparam int WE    = 2;
   localparam int SW    = 6;
   localparam logic [31:0] SMAX = 32'd63;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic [31:0] stall_cnt;
   always #5 clk = ~clk;

   multi_bank_arb_ram_if #(.PORTS(PORTS), .WIDTH(WIDTH), .ADDR(ADDR), .WE(WE)) bus ();

   multi_bank_arb_ram #(
      .BANKS(BANKS), .PORTS(PORTS), .WIDTH(WIDTH), .DEPTH(DEPTH),
      .ADDR(ADDR), .WE(WE), .STALL_W(SW)
   ) dut (
      .clk(clk), .rstn(rstn), .bus(bus), .stall_cnt(stall_cnt)
   );

   typedef struct {
      int          due;
      logic [15:0] d;
      bit          k;
   } rsp_t;

   int          vectors = 0;
   int          errors  = 0;
   int          edge_cnt = 0;
   logic [15:0] mmem   [BANKS*DEPTH];
   bit          mknown [BANKS*DEPTH];
   int          rr     [BANKS];
   logic [31:0] m_stall;
   rsp_t        rq     [PORTS][$];
   logic [PORTS-1:0] exp_vld;
   logic [15:0] exp_dat [PORTS];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic int addr_of(int p);
      return int'(bus.req_addr[p*ADDR +: ADDR]);
   endfunction

   function automatic logic [PORTS-1:0] model_grant();
      logic [PORTS-1:0] g;
      g = '0;
      for (int b = 0; b < BANKS; b++) begin
         for (int i = 0; i < PORTS; i++) begin
            int p;
            p = (rr[b] + i) % PORTS;
            if (bus.req_valid[p] && addr_of(p) % BANKS == b) begin
               g[p] = 1'b1;
               break;
            end
         end
      end
      return g;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < BANKS; b++) rr[b] = 0;
      m_stall = 0;
      for (int p = 0; p < PORTS; p++) begin
         rq[p].delete();
         exp_dat[p] = '0;
      end
      exp_vld = '0;
   endtask

   // One clock cycle: compare at negedge+1, then advance the model at the rising edge.
   task automatic step();
      logic [PORTS-1:0] g;
      #1;
      g = model_grant();
      chk("req_ready", 32'(bus.req_ready), 32'(g));
      chk("stall_cnt", stall_cnt, m_stall);
      for (int p = 0; p < PORTS; p++) begin
         chk("rsp_valid", 32'(bus.rsp_valid[p]), 32'(exp_vld[p]));
         chk("rsp_rdata", 32'(bus.rsp_rdata[p*WIDTH +: WIDTH]), 32'(exp_dat[p]));
      end
      @(posedge clk);
      if (rstn) begin
         edge_cnt++;
         if (|(bus.req_valid & ~g))
            m_stall = (m_stall == SMAX) ? SMAX : m_stall + 1;
         for (int p = 0; p < PORTS; p++) begin
            if (g[p]) begin
               int          a;
               logic [1:0]  we;
               logic [15:0] wd;
               rsp_t        r;
               a  = addr_of(p);
               we = bus.req_we[p*WE +: WE];
               wd = bus.req_wdata[p*WIDTH +: WIDTH];
               if (we != 2'b00) begin
                  if (we[0]) mmem[a][7:0]  = wd[7:0];
                  if (we[1]) mmem[a][15:8] = wd[15:8];
                  mknown[a] = mknown[a] || (we == 2'b11);
               end else begin
                  r.due = edge_cnt + 2;
                  r.d   = mmem[a];
                  r.k   = mknown[a];
                  rq[p].push_back(r);
               end
               rr[a % BANKS] = (p + 1) % PORTS;
            end
         end
         for (int p = 0; p < PORTS; p++) begin
            exp_vld[p] = 1'b0;
            if (rq[p].size() > 0 && rq[p][0].due == edge_cnt) begin
               exp_vld[p] = 1'b1;
               exp_dat[p] = rq[p][0].k ? rq[p][0].d : bus.rsp_rdata[p*WIDTH +: WIDTH];
               void'(rq[p].pop_front());
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic req(int p, bit v, logic [1:0] we, int a, logic [15:0] wd);
      bus.req_valid[p]                = v;
      bus.req_we[p*WE +: WE]          = we;
      bus.req_addr[p*ADDR +: ADDR]    = ADDR'(a);
      bus.req_wdata[p*WIDTH +: WIDTH] = wd;
   endtask

   task automatic idle();
      bus.req_valid = '0;
      bus.req_we    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      model_reset();
      rstn = 1'b0;
      @(negedge clk);
      step();
      step();
      rstn = 1'b1;
      step();

      // Write then read-back on the next edge.
      req(0, 1, 2'b11, 5, 16'hBEEF); step();
      req(0, 1, 2'b00, 5, 16'h0);    step();
      idle(); step(); step();
      #1;
      chk("beef_vld", 32'(bus.rsp_valid[0]), 32'd1);
      chk("beef_dat", 32'(bus.rsp_rdata[15:0]), 32'hBEEF);

      // Full write followed by a high-byte-only write.
      req(1, 1, 2'b11, 2, 16'h1234); step();
      req(1, 1, 2'b10, 2, 16'hAB00); step();
      req(1, 1, 2'b00, 2, 16'h0);    step();
      idle(); step(); step();
      #1;
      chk("bytewr_vld", 32'(bus.rsp_valid[1]), 32'd1);
      chk("bytewr_dat", 32'(bus.rsp_rdata[31:16]), 32'hAB34);

      // Different banks in the same cycle: both granted, no stall.
      req(0, 1, 2'b11, 0, 16'h1111);
      req(1, 1, 2'b11, 1, 16'h2222); step();
      req(0, 1, 2'b00, 0, 16'h0);
      req(1, 1, 2'b00, 1, 16'h0);
      #1;
      chk("par_ready", 32'(bus.req_ready), 32'h3);
      step();
      idle(); step(); step();
      #1;
      chk("par_vld", 32'(bus.rsp_valid), 32'h3);
      chk("par_dat0", 32'(bus.rsp_rdata[15:0]), 32'h1111);
      chk("par_dat1", 32'(bus.rsp_rdata[31:16]), 32'h2222);
      chk("par_stall", stall_cnt, 32'd0);
      req(0, 1, 2'b11, 9, 16'h9999); step();
      idle(); step();

      // Read in flight when reset hits must be dropped.
      req(0, 1, 2'b00, 2, 16'h0); step();
      idle();
      rstn = 1'b0;
      model_reset();
      step(); step();
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) step();
      #1;
      chk("rst_vld", 32'(bus.rsp_valid), 32'd0);
      chk("rst_stall", stall_cnt, 32'd0);

      // Same-bank conflict from reset: alternate grants, one stall per cycle, then saturation.
      req(0, 1, 2'b00, 1, 16'h0);
      req(1, 1, 2'b00, 9, 16'h0);
      #1;
      chk("alt0", 32'(bus.req_ready), 32'h1);
      step();
      #1;
      chk("alt1", 32'(bus.req_ready), 32'h2);
      chk("stall1", stall_cnt, 32'd1);
      step();
      #1;
      chk("alt2", 32'(bus.req_ready), 32'h1);
      chk("stall2", stall_cnt, 32'd2);
      step();
      #1;
      chk("conf_dat0", 32'(bus.rsp_rdata[15:0]), 32'h2222);
      for (int i = 0; i < 70; i++) step();
      #1;
      chk("sat", stall_cnt, 32'd63);
      step(); step();
      #1;
      chk("sat_hold", stall_cnt, 32'd63);
      idle(); step(); step();

      // Data written before reset persists.
      req(0, 1, 2'b00, 5, 16'h0); step();
      idle(); step(); step();
      #1;
      chk("persist_vld", 32'(bus.rsp_valid[0]), 32'd1);
      chk("persist_dat", 32'(bus.rsp_rdata[15:0]), 32'hBEEF);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
